// File: rtl/delay_sweep_ctrl.sv
// Delay sweep sequencer: steps the pulse-generator delay through n_steps points,
// holding each point for n_shots periods aligned to period_tick boundaries.
module delay_sweep_ctrl #(
  parameter logic [15:0] RST_DELAY = 16'd200,
  parameter int unsigned SHOT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              period_tick,
  input  logic [15:0]       base_del,
  input  logic [15:0]       step_del,
  input  logic              step_dn,
  input  logic [7:0]        n_steps,
  input  logic [SHOT_W-1:0] n_shots,
  output logic [15:0]       del_out,
  output logic              run_en,
  output logic              busy,
  output logic [7:0]        step_idx,
  output logic [SHOT_W-1:0] shot_idx,
  output logic              done,
  output logic              aborted,
  output logic              sat,
  output logic              cfg_err
);

  localparam int unsigned DEL_W  = 16;
  localparam int unsigned STEP_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [DEL_W-1:0]    step_del_q, step_del_d;
  logic                step_dn_q, step_dn_d;
  logic [STEP_W-1:0]   n_steps_q, n_steps_d;
  logic [SHOT_W-1:0]   n_shots_q, n_shots_d;

  logic [DEL_W-1:0]    del_d;
  logic                run_en_d, busy_d, done_d, aborted_d, sat_d, cfg_err_d;
  logic [STEP_W-1:0]   step_idx_d;
  logic [SHOT_W-1:0]   shot_idx_d;

  // Next delay point with 17-bit arithmetic; carry/borrow means clamp
  logic [DEL_W:0]      del_sum, del_dif;
  logic [DEL_W-1:0]    del_step;
  logic                del_clamp;
  logic                last_shot, last_step;

  always_comb begin
    del_sum = {1'b0, del_out} + {1'b0, step_del_q};
    del_dif = {1'b0, del_out} - {1'b0, step_del_q};
    if (step_dn_q) begin
      del_clamp = del_dif[DEL_W];
      del_step  = del_clamp ? '0 : del_dif[DEL_W-1:0];
    end else begin
      del_clamp = del_sum[DEL_W];
      del_step  = del_clamp ? '1 : del_sum[DEL_W-1:0];
    end
  end

  assign last_shot = (shot_idx == n_shots_q - SHOT_W'(1));
  assign last_step = (step_idx == n_steps_q - STEP_W'(1));

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    step_del_d = step_del_q;
    step_dn_d  = step_dn_q;
    n_steps_d  = n_steps_q;
    n_shots_d  = n_shots_q;
    del_d      = del_out;
    run_en_d   = run_en;
    step_idx_d = step_idx;
    shot_idx_d = shot_idx;
    sat_d      = sat;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    cfg_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        del_d    = RST_DELAY;
        run_en_d = 1'b0;
        if (start && !abort) begin
          if (n_steps == '0 || n_shots == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            step_del_d = step_del;
            step_dn_d  = step_dn;
            n_steps_d  = n_steps;
            n_shots_d  = n_shots;
            del_d      = base_del;
            step_idx_d = '0;
            shot_idx_d = '0;
            sat_d      = 1'b0;
            state_d    = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d   = S_IDLE;
          run_en_d  = 1'b0;
          aborted_d = 1'b1;
        end else if (period_tick) begin
          state_d  = S_RUN;
          run_en_d = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          run_en_d  = 1'b0;
          aborted_d = 1'b1;
        end else if (period_tick) begin
          if (!last_shot) begin
            shot_idx_d = shot_idx + SHOT_W'(1);
          end else if (!last_step) begin
            shot_idx_d = '0;
            step_idx_d = step_idx + STEP_W'(1);
            del_d      = del_step;
            if (del_clamp) sat_d = 1'b1;
          end else begin
            state_d  = S_FIN;
            run_en_d = 1'b0;
          end
        end
      end
      S_FIN: begin
        run_en_d = 1'b0;
        state_d  = S_IDLE;
        if (abort) aborted_d = 1'b1;
        else       done_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      step_del_q <= '0;
      step_dn_q  <= 1'b0;
      n_steps_q  <= '0;
      n_shots_q  <= '0;
      del_out    <= RST_DELAY;
      run_en     <= 1'b0;
      busy       <= 1'b0;
      step_idx   <= '0;
      shot_idx   <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      sat        <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_del_q <= step_del_d;
      step_dn_q  <= step_dn_d;
      n_steps_q  <= n_steps_d;
      n_shots_q  <= n_shots_d;
      del_out    <= del_d;
      run_en     <= run_en_d;
      busy       <= busy_d;
      step_idx   <= step_idx_d;
      shot_idx   <= shot_idx_d;
      done       <= done_d;
      aborted    <= aborted_d;
      sat        <= sat_d;
      cfg_err    <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Scoreboard bench for delay_sweep_ctrl: stimulus pushes expected events from a
// sweep model; a negedge monitor pops and compares whenever the DUT reports one.
module tb_delay_sweep_ctrl;

  localparam logic [15:0] RST_DELAY = 16'd200;
  localparam int unsigned SHOT_W    = 16;

  localparam int K_PER   = 0;
  localparam int K_DONE  = 1;
  localparam int K_ABORT = 2;
  localparam int K_CFG   = 3;
  localparam int K_RST   = 4;

  logic              clk;
  logic              reset;
  logic              start, abort, period_tick;
  logic [15:0]       base_del, step_del;
  logic              step_dn;
  logic [7:0]        n_steps;
  logic [SHOT_W-1:0] n_shots;
  logic [15:0]       del_out;
  logic              run_en, busy, done, aborted, sat, cfg_err;
  logic [7:0]        step_idx;
  logic [SHOT_W-1:0] shot_idx;

  delay_sweep_ctrl #(.RST_DELAY(RST_DELAY), .SHOT_W(SHOT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .period_tick(period_tick), .base_del(base_del), .step_del(step_del),
    .step_dn(step_dn), .n_steps(n_steps), .n_shots(n_shots),
    .del_out(del_out), .run_en(run_en), .busy(busy), .step_idx(step_idx),
    .shot_idx(shot_idx), .done(done), .aborted(aborted), .sat(sat),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int del;
    int step;
    int shot;
    int sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sweep model: point s sits at base +/- s*step, clamped to 16 bits
  function automatic exp_t mk_period(input int base, input int step, input int dn,
                                     input int nsh, input int p);
    exp_t e;
    int   s, raw;
    s   = p / nsh;
    raw = dn ? base - s * step : base + s * step;
    e.kind = K_PER;
    e.step = s;
    e.shot = p % nsh;
    e.sat  = (raw < 0 || raw > 65535) ? 1 : 0;
    e.del  = raw < 0 ? 0 : (raw > 65535 ? 65535 : raw);
    return e;
  endfunction

  // Monitor side: inputs captured at the active edge, outputs sampled on negedge
  logic tick_q = 1'b0;
  logic rst_q  = 1'b1;
  always @(posedge clk) begin
    tick_q <= period_tick;
    rst_q  <= reset;
  end

  task automatic pop_exp(input int kind, input string name, output exp_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e  = '{default: 0};
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: unexpected event, got kind %0d expected none at %0t", name, kind, $time);
    end else if (exp_q[0].kind != kind) begin
      failures++;
      $display("FAIL %s: got event kind %0d expected kind %0d at %0t", name, kind, exp_q[0].kind, $time);
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  bit   run_en_prev = 1'b0;
  bit   post_chk    = 1'b0;
  exp_t me;
  bit   mok;

  always @(negedge clk) begin
    if (!rst_q) begin
      pop_exp(K_RST, "reset_evt", me, mok);
      if (mok) begin
        chk("rst_del", del_out, int'(RST_DELAY));
        chk("rst_run_en", run_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step", step_idx, 0);
        chk("rst_shot", shot_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_sat", sat, 0);
        chk("rst_cfg_err", cfg_err, 0);
      end
      post_chk = 1'b0;
    end else begin
      if (post_chk) begin
        chk("del_restore", del_out, int'(RST_DELAY));
        post_chk = 1'b0;
      end
      if (run_en === 1'b1 && (!run_en_prev || tick_q === 1'b1)) begin
        pop_exp(K_PER, "period_evt", me, mok);
        if (mok) begin
          chk("per_del", del_out, me.del);
          chk("per_step", step_idx, me.step);
          chk("per_shot", shot_idx, me.shot);
          chk("per_sat", sat, me.sat);
        end
      end
      if (done === 1'b1) begin
        pop_exp(K_DONE, "done_evt", me, mok);
        if (mok) begin
          chk("done_del", del_out, me.del);
          chk("done_step", step_idx, me.step);
          chk("done_shot", shot_idx, me.shot);
          chk("done_sat", sat, me.sat);
          chk("done_busy", busy, 0);
          chk("done_run_en", run_en, 0);
        end
        post_chk = 1'b1;
      end
      if (aborted === 1'b1) begin
        pop_exp(K_ABORT, "abort_evt", me, mok);
        if (mok) begin
          chk("abort_del", del_out, me.del);
          chk("abort_step", step_idx, me.step);
          chk("abort_shot", shot_idx, me.shot);
          chk("abort_sat", sat, me.sat);
          chk("abort_busy", busy, 0);
          chk("abort_run_en", run_en, 0);
          chk("abort_done", done, 0);
        end
        post_chk = 1'b1;
      end
      if (cfg_err === 1'b1) begin
        pop_exp(K_CFG, "cfg_evt", me, mok);
        if (mok) begin
          chk("cfg_busy", busy, 0);
          chk("cfg_del", del_out, int'(RST_DELAY));
        end
      end
    end
    run_en_prev = (run_en === 1'b1);
  end

  // Stimulus side
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e = '{kind: K_RST, del: 0, step: 0, shot: 0, sat: 0};
    reset = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
    cyc(n);
    reset = 1'b1;
  endtask

  // mode 0: complete; 1: abort together with tick a; 2: abort in FIN; 3: reset before tick a
  task automatic run_sweep(input int base, input int step, input int dn, input int ns,
                           input int nsh, input int gap, input int mode, input int a);
    exp_t e;
    int   np, emit, n;
    np   = ns * nsh;
    emit = (mode == 1 || mode == 3) ? a : np;
    for (int p = 0; p < emit; p++) exp_q.push_back(mk_period(base, step, dn, nsh, p));
    case (mode)
      0, 2: begin
        e = mk_period(base, step, dn, nsh, np - 1);
        e.kind = (mode == 0) ? K_DONE : K_ABORT;
      end
      1: begin
        if (a == 0) e = '{kind: K_ABORT, del: base, step: 0, shot: 0, sat: 0};
        else begin
          e = mk_period(base, step, dn, nsh, a - 1);
          e.kind = K_ABORT;
        end
      end
      default: e = '{kind: K_RST, del: 0, step: 0, shot: 0, sat: 0};
    endcase
    exp_q.push_back(e);

    base_del = 16'(base);
    step_del = 16'(step);
    step_dn  = 1'(dn);
    n_steps  = 8'(ns);
    n_shots  = SHOT_W'(nsh);
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
    base_del = 16'($urandom);
    step_del = 16'($urandom);
    step_dn  = 1'($urandom);
    n_steps  = 8'($urandom);
    n_shots  = SHOT_W'($urandom);

    for (int t = 0; t <= np; t++) begin
      cyc(gap);
      if (t == 1) begin
        base_del = 16'($urandom);
        start    = 1'b1;
        cyc(1);
        start    = 1'b0;
      end
      if (mode == 1 && t == a) begin
        period_tick = 1'b1;
        abort       = 1'b1;
        cyc(1);
        period_tick = 1'b0;
        abort       = 1'b0;
        break;
      end
      if (mode == 3 && t == a) begin
        reset = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        cyc(1);
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        break;
      end
      period_tick = 1'b1;
      cyc(1);
      period_tick = 1'b0;
      if (mode == 2 && t == np) begin
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
      end
    end

    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      cyc(1);
      n++;
    end
    chk("idle_after_sweep", busy, 0);
    cyc(4);
  endtask

  task automatic cfg_reject(input int ns, input int nsh);
    exp_t e;
    e = '{kind: K_CFG, del: 0, step: 0, shot: 0, sat: 0};
    exp_q.push_back(e);
    base_del = 16'($urandom);
    n_steps  = 8'(ns);
    n_shots  = SHOT_W'(nsh);
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
    cyc(3);
  endtask

  initial begin
    int base, step, ns, nsh, mode, a, np;
    reset = 1'b0; start = 1'b0; abort = 1'b0; period_tick = 1'b0;
    base_del = '0; step_del = '0; step_dn = 1'b0; n_steps = '0; n_shots = '0;
    do_reset(3);
    cyc(2);

    run_sweep(100, 50, 0, 3, 2, 20, 0, 0);
    run_sweep(16'hFFF0, 16'h20, 0, 2, 1, 3, 0, 0);
    run_sweep(10, 20, 1, 2, 1, 3, 0, 0);
    cfg_reject(3, 0);
    cfg_reject(0, 2);

    // start with abort, and ticks, while idle: nothing may happen
    n_steps = 8'd2; n_shots = SHOT_W'(2); start = 1'b1; abort = 1'b1;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    cyc(2);
    period_tick = 1'b1;
    cyc(1);
    period_tick = 1'b0;
    cyc(3);
    chk("idle_ignore_busy", busy, 0);

    run_sweep(300, 7, 0, 3, 2, 2, 1, 3);
    run_sweep(1000, 100, 1, 3, 2, 2, 3, 3);
    run_sweep(500, 25, 0, 2, 2, 2, 0, 0);
    run_sweep(40, 3, 0, 2, 2, 2, 1, 0);
    run_sweep(40, 3, 1, 2, 2, 2, 2, 0);

    for (int i = 0; i < 30; i++) begin
      base = (i % 3 == 0) ? int'($urandom_range(0, 64)) :
             (i % 3 == 1) ? int'($urandom_range(65400, 65535)) : int'($urandom_range(0, 65535));
      step = int'($urandom_range(0, 65535) >> $urandom_range(4, 15));
      ns   = int'($urandom_range(1, 6));
      nsh  = int'($urandom_range(1, 4));
      np   = ns * nsh;
      mode = int'($urandom_range(0, 3));
      a    = 0;
      if (mode == 1) a = int'($urandom_range(0, np));
      if (mode == 3) begin
        if (np < 2) mode = 0;
        else a = int'($urandom_range(1, np - 1));
      end
      run_sweep(base, step, int'($urandom_range(0, 1)), ns, nsh,
                int'($urandom_range(1, 4)), mode, a);
      if (i % 7 == 3) cfg_reject(int'($urandom_range(0, 1)) * 5, 0);
    end

    cyc(5);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
